ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx.sv | 224 ++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, start, 8 data LSB first, odd parity, stop, ACK.
// Optional macro PS2_TX_TIMEOUT_EN adds a device-clock watchdog that aborts a stalled transfer.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_async,
  input  logic       ps2_data_async,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  localparam logic [19:0] INH_LAST = 20'(INHIBIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic        parity_q, parity_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [19:0] inh_cnt_q, inh_cnt_d;
  logic        clk_oe_q, clk_oe_d;
  logic        data_oe_q, data_oe_d;
  logic        tx_done_q, tx_done_d;
  logic        tx_error_q, tx_error_d;
  logic        tx_ready_q, tx_ready_d;
  logic        busy_q, busy_d;

  logic        clk_meta_q, clk_sync_q, clk_prev_q;
  logic        data_meta_q, data_sync_q;
  logic        fe;

`ifdef PS2_TX_TIMEOUT_EN
  localparam logic [19:0] TMO_LAST = 20'(TIMEOUT_CYCLES - 1);
  logic [19:0] tmo_cnt_q, tmo_cnt_d;
  logic        in_xfer;
`endif

  assign fe = clk_prev_q & ~clk_sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= ps2_clk_async;
      clk_sync_q  <= clk_meta_q;
      clk_prev_q  <= clk_sync_q;
      data_meta_q <= ps2_data_async;
      data_sync_q <= data_meta_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    bit_cnt_d  = bit_cnt_q;
    inh_cnt_d  = inh_cnt_q;
    clk_oe_d   = clk_oe_q;
    data_oe_d  = data_oe_q;
    tx_done_d  = 1'b0;
    tx_error_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (tx_valid && tx_ready_q) begin
          shift_d   = tx_data;
          parity_d  = ~^tx_data;
          bit_cnt_d = 3'd0;
          inh_cnt_d = 20'd0;
          clk_oe_d  = 1'b1;
          state_d   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        // Start bit is placed on data in the same cycle the clock is released.
        if (inh_cnt_q >= INH_LAST) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          state_d   = S_DATA;
        end else if (inh_cnt_q != 20'hFFFFF) begin
          inh_cnt_d = inh_cnt_q + 20'd1;
        end
      end
      S_DATA: begin
        if (fe) begin
          data_oe_d = ~shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_PARITY;
          end
        end
      end
      S_PARITY: begin
        if (fe) begin
          data_oe_d = ~parity_q;
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (fe) begin
          data_oe_d = 1'b0;
          state_d   = S_ACK;
        end
      end
      S_ACK: begin
        data_oe_d = 1'b0;
        if (fe) begin
          if (!data_sync_q) begin
            state_d = S_WAIT_IDLE;
          end else begin
            tx_error_d = 1'b1;
            state_d    = S_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        data_oe_d = 1'b0;
        if (clk_sync_q && data_sync_q) begin
          tx_done_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    in_xfer = (state_q == S_DATA) || (state_q == S_PARITY) || (state_q == S_STOP) ||
              (state_q == S_ACK) || (state_q == S_WAIT_IDLE);
    if (!in_xfer || fe) begin
      tmo_cnt_d = 20'd0;
    end else if (tmo_cnt_q != 20'hFFFFF) begin
      tmo_cnt_d = tmo_cnt_q + 20'd1;
    end else begin
      tmo_cnt_d = tmo_cnt_q;
    end
    // A stalled device wins over any completion decided in the same cycle.
    if (in_xfer && !fe && (tmo_cnt_q >= TMO_LAST)) begin
      clk_oe_d   = 1'b0;
      data_oe_d  = 1'b0;
      tx_done_d  = 1'b0;
      tx_error_d = 1'b1;
      tmo_cnt_d  = 20'd0;
      state_d    = S_IDLE;
    end
`endif

    tx_ready_d = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      shift_q    <= 8'd0;
      parity_q   <= 1'b0;
      bit_cnt_q  <= 3'd0;
      inh_cnt_q  <= 20'd0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_error_q <= 1'b0;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      bit_cnt_q  <= bit_cnt_d;
      inh_cnt_q  <= inh_cnt_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
      tx_done_q  <= tx_done_d;
      tx_error_q <= tx_error_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
    end
  end

`ifdef PS2_TX_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_q <= 20'd0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`endif

  assign tx_ready    = tx_ready_q;
  assign tx_done     = tx_done_q;
  assign tx_error    = tx_error_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: an open-drain bus plus a device model that clocks frames and ACKs.
module tb_ps2_host_tx;

  localparam int HALF   = 20;
  localparam int TB_INH = 5000;
  localparam int TB_TMO = 300;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready, tx_done, tx_error;
  logic       ps2_clk_oe, ps2_data_oe, busy;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_line, ps2_data_line;

  int total = 0;
  int bad   = 0;
  int cyc = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0, oe_hi = 0;
  int last_fe_cyc = 0;
  int d0, e0, o0;
  logic [10:0] frame;

  always #10 clk = ~clk;

  assign ps2_clk_line  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_line = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(TB_INH),
    .TIMEOUT_CYCLES(TB_TMO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data),
    .tx_ready      (tx_ready),
    .tx_done       (tx_done),
    .tx_error      (tx_error),
    .ps2_clk_async (ps2_clk_line),
    .ps2_data_async(ps2_data_line),
    .ps2_clk_oe    (ps2_clk_oe),
    .ps2_data_oe   (ps2_data_oe),
    .busy          (busy)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_done) done_cnt <= done_cnt + 1;
    if (tx_error) err_cnt <= err_cnt + 1;
    if (tx_done && tx_error) both_cnt <= both_cnt + 1;
    if (ps2_clk_oe) oe_hi <= oe_hi + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    d0 = done_cnt;
    e0 = err_cnt;
    o0 = oe_hi;
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!tx_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, tx_ready}, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  // Device side: wait out the inhibit, then clock n_fe pulses sampling data on each rise.
  task automatic dev_xfer(input int n_fe, input bit ack, input bit poke, output logic [10:0] fr);
    int n;
    fr = '0;
    n  = 0;
    while (ps2_clk_oe && n < TB_INH + 100) begin
      @(negedge clk);
      n++;
    end
    check("clk_release", {31'd0, ps2_clk_oe}, 32'd0);
    fr[0] = ps2_data_line;
    for (int i = 1; i <= n_fe; i++) begin
      if (i == 11 && ack) dev_data = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk     = 1'b0;
      last_fe_cyc = cyc;
      if (poke && i == 4) begin
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
      end
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      if (i <= 10) fr[i] = ps2_data_line;
    end
    if (ack && n_fe == 11) begin
      repeat (HALF) @(negedge clk);
      dev_data = 1'b1;
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready",  {31'd0, tx_ready},    32'd1);
    check("rst_busy",   {31'd0, busy},        32'd0);
    check("rst_done",   {31'd0, tx_done},     32'd0);
    check("rst_error",  {31'd0, tx_error},    32'd0);
    check("rst_clk_oe", {31'd0, ps2_clk_oe},  32'd0);
    check("rst_dat_oe", {31'd0, ps2_data_oe}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // 0xED: start 0, data 1,0,1,1,0,1,1,1, parity 1, stop 1
    snap();
    send(8'hED);
    check("ed_busy", {31'd0, busy}, 32'd1);
    dev_xfer(11, 1'b1, 1'b0, frame);
    wait_ready("ed_ready");
    check("ed_frame",  {21'd0, frame},   32'h7DA);
    check("ed_done",   done_cnt - d0,    32'd1);
    check("ed_err",    err_cnt - e0,     32'd0);
    check("ed_inhibit", oe_hi - o0,      32'd5000);

    // 0x00 then 0xFF back to back; eight ones still need a parity 1 for odd parity
    snap();
    send(8'h00);
    dev_xfer(11, 1'b1, 1'b0, frame);
    wait_ready("z_ready");
    check("z_frame", {21'd0, frame}, 32'h600);
    send(8'hFF);
    dev_xfer(11, 1'b1, 1'b0, frame);
    wait_ready("ff_ready");
    check("ff_frame", {21'd0, frame}, 32'h7FE);
    check("zff_done", done_cnt - d0,  32'd2);

    // No ACK: data left high on the 11th clock
    snap();
    send(8'hA5);
    dev_xfer(11, 1'b0, 1'b0, frame);
    wait_ready("nack_ready");
    check("nack_frame",  {21'd0, frame},        32'h74A);
    check("nack_err",    err_cnt - e0,          32'd1);
    check("nack_done",   done_cnt - d0,         32'd0);
    check("nack_clk_oe", {31'd0, ps2_clk_oe},   32'd0);
    check("nack_dat_oe", {31'd0, ps2_data_oe},  32'd0);

    // Reset after the 3rd falling edge while a zero bit is being driven
    snap();
    send(8'h00);
    dev_xfer(3, 1'b0, 1'b0, frame);
    check("prerst_dat_oe", {31'd0, ps2_data_oe}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mrst_clk_oe", {31'd0, ps2_clk_oe},  32'd0);
    check("mrst_dat_oe", {31'd0, ps2_data_oe}, 32'd0);
    check("mrst_ready",  {31'd0, tx_ready},    32'd1);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("mrst_nopulse", (done_cnt - d0) + (err_cnt - e0), 32'd0);
    send(8'hED);
    dev_xfer(11, 1'b1, 1'b0, frame);
    wait_ready("post_rst_ready");
    check("post_rst_frame", {21'd0, frame}, 32'h7DA);
    check("post_rst_done",  done_cnt - d0,  32'd1);

    // tx_valid with 0x55 during DATA must not disturb the 0xED frame
    snap();
    send(8'hED);
    dev_xfer(11, 1'b1, 1'b1, frame);
    wait_ready("poke_ready");
    check("poke_frame", {21'd0, frame}, 32'h7DA);
    check("poke_done",  done_cnt - d0,  32'd1);
    check("poke_err",   err_cnt - e0,   32'd0);

`ifdef PS2_TX_TIMEOUT_EN
    begin
      int n;
      int delta;
      snap();
      send(8'h00);
      dev_xfer(4, 1'b0, 1'b0, frame);
      n = 0;
      while (!tx_error && n < TB_TMO + 200) begin
        @(negedge clk);
        n++;
      end
      delta = cyc - last_fe_cyc;
      check("tmo_seen",   {31'd0, tx_error}, 32'd1);
      check("tmo_window", {31'd0, (delta >= TB_TMO) && (delta <= TB_TMO + 6)}, 32'd1);
      repeat (2) @(negedge clk);
      check("tmo_ready",  {31'd0, tx_ready},    32'd1);
      check("tmo_clk_oe", {31'd0, ps2_clk_oe},  32'd0);
      check("tmo_dat_oe", {31'd0, ps2_data_oe}, 32'd0);
      check("tmo_done",   done_cnt - d0,        32'd0);
    end
`endif

    check("never_both", both_cnt, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
